// File: rtl/beep_sched.sv
// Buzzer scheduler: arbitrates three beep requesters onto one active-low buzzer
// output, playing a fixed per-channel pattern of N beeps followed by a silent gap.
module beep_sched #(
  parameter int unsigned MS_CNT  = 50000,
  parameter int unsigned CH0_N   = 1,
  parameter int unsigned CH0_ON  = 50,
  parameter int unsigned CH0_OFF = 50,
  parameter int unsigned CH1_N   = 2,
  parameter int unsigned CH1_ON  = 100,
  parameter int unsigned CH1_OFF = 100,
  parameter int unsigned CH2_N   = 5,
  parameter int unsigned CH2_ON  = 200,
  parameter int unsigned CH2_OFF = 200,
  parameter int unsigned GAP_MS  = 100
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] req,
  output logic       beep,
  output logic       busy,
  output logic [2:0] grant,
  output logic       done
);

  // Keep the prescaler at least one bit wide so MS_CNT=1 still elaborates.
  localparam int unsigned PreW = (MS_CNT > 1) ? $clog2(MS_CNT) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(MS_CNT - 1);

  localparam logic [9:0] Ch0N   = 10'(CH0_N);
  localparam logic [9:0] Ch0On  = 10'(CH0_ON);
  localparam logic [9:0] Ch0Off = 10'(CH0_OFF);
  localparam logic [9:0] Ch1N   = 10'(CH1_N);
  localparam logic [9:0] Ch1On  = 10'(CH1_ON);
  localparam logic [9:0] Ch1Off = 10'(CH1_OFF);
  localparam logic [9:0] Ch2N   = 10'(CH2_N);
  localparam logic [9:0] Ch2On  = 10'(CH2_ON);
  localparam logic [9:0] Ch2Off = 10'(CH2_OFF);
  localparam logic [9:0] GapMs  = 10'(GAP_MS);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

  state_e          state_q, state_d;
  logic [2:0]      pend_q, pend_d;
  logic [2:0]      grant_q, grant_d;
  logic            beep_q, beep_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic [9:0]      ms_q, ms_d;
  logic [9:0]      left_q, left_d;
  logic [9:0]      on_ms_q, on_ms_d;
  logic [9:0]      off_ms_q, off_ms_d;

  logic [9:0]      dur;
  logic            expire;
  logic [2:0]      sel;

  // Next-state logic: arbitration, pattern sequencing, timer and registered outputs.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q | req;
    grant_d  = grant_q;
    left_d   = left_q;
    on_ms_d  = on_ms_q;
    off_ms_d = off_ms_q;
    sel      = 3'b000;
    pre_d    = '0;
    ms_d     = '0;

    unique case (state_q)
      StOn:    dur = on_ms_q;
      StOff:   dur = off_ms_q;
      StGap:   dur = GapMs;
      default: dur = 10'd1;
    endcase
    expire = (pre_q == PreMax) && (ms_q == dur - 10'd1);

    unique case (state_q)
      StIdle: begin
        if (pend_q != 3'b000) begin
          if (pend_q[2]) begin
            sel = 3'b100;
            left_d = Ch2N; on_ms_d = Ch2On; off_ms_d = Ch2Off;
          end else if (pend_q[1]) begin
            sel = 3'b010;
            left_d = Ch1N; on_ms_d = Ch1On; off_ms_d = Ch1Off;
          end else begin
            sel = 3'b001;
            left_d = Ch0N; on_ms_d = Ch0On; off_ms_d = Ch0Off;
          end
          state_d = StOn;
          grant_d = sel;
          // A request arriving on the grant edge re-arms the bit for a replay.
          pend_d  = (pend_q & ~sel) | req;
        end
      end
      StOn: begin
        if (expire) begin
          left_d  = left_q - 10'd1;
          state_d = (left_q > 10'd1) ? StOff : StGap;
        end
      end
      StOff: begin
        if (expire) state_d = StOn;
      end
      StGap: begin
        if (expire) begin
          state_d = StIdle;
          grant_d = 3'b000;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timer restarts on every state entry so each state lasts exactly dur*MS_CNT cycles.
    if (state_d == state_q && state_q != StIdle) begin
      if (pre_q == PreMax) begin
        pre_d = '0;
        ms_d  = ms_q + 10'd1;
      end else begin
        pre_d = pre_q + PreW'(1);
        ms_d  = ms_q;
      end
    end

    beep_d = (state_d != StOn);
    busy_d = (state_d != StIdle);
    // Look ahead one cycle so the registered pulse lands in the final gap cycle.
    done_d = (state_d == StGap) && (pre_d == PreMax) && (ms_d == GapMs - 10'd1);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      pend_q   <= 3'b000;
      grant_q  <= 3'b000;
      beep_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pre_q    <= '0;
      ms_q     <= '0;
      left_q   <= '0;
      on_ms_q  <= '0;
      off_ms_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      grant_q  <= grant_d;
      beep_q   <= beep_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pre_q    <= pre_d;
      ms_q     <= ms_d;
      left_q   <= left_d;
      on_ms_q  <= on_ms_d;
      off_ms_q <= off_ms_d;
    end
  end

  assign beep  = beep_q;
  assign busy  = busy_q;
  assign grant = grant_q;
  assign done  = done_q;

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched with a small-scale timing configuration.
module tb_beep_sched;

  localparam int MS  = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b111;
  logic       beep, busy, done;
  logic [2:0] grant;

  int total = 0;
  int bad   = 0;

  beep_sched #(
    .MS_CNT (MS),
    .CH0_N  (1), .CH0_ON (1), .CH0_OFF (1),
    .CH1_N  (2), .CH1_ON (2), .CH1_OFF (1),
    .CH2_N  (3), .CH2_ON (1), .CH2_OFF (2),
    .GAP_MS (GAP)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .req     (req),
    .beep    (beep),
    .busy    (busy),
    .grant   (grant),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       chk;
    logic [5:0] exp;  // {beep, busy, grant, done}
  } vec_t;

  vec_t vecs[26];

  // One cycle: drive inputs just after the edge, sample outputs mid-cycle.
  task automatic step(input logic r, input logic [2:0] q);
    @(posedge clk);
    #1;
    rst = r;
    req = q;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference beep level t cycles after the first low cycle of a pattern.
  function automatic logic exp_beep(input int t, input int n, input int on, input int off);
    int u;
    u = t / MS;
    for (int i = 0; i < n; i++) begin
      if (u < on) return 1'b0;
      u -= on;
      if (i < n - 1) begin
        if (u < off) return 1'b1;
        u -= off;
      end
    end
    return 1'b1;
  endfunction

  // Checks a full pattern starting at its first low cycle, then the mandatory idle cycle.
  task automatic play(input string nm, input int n, input int on, input int off,
                      input logic [2:0] g, input int inj_t, input logic [2:0] inj_req);
    int   len;
    int   eb, eg, dn, dpos, lows;
    logic prev;
    len  = (n * on + (n - 1) * off + GAP) * MS;
    eb   = 0; eg = 0; dn = 0; dpos = -1; lows = 0; prev = 1'b1;
    for (int t = 0; t < len; t++) begin
      step(1'b0, (t == inj_t) ? inj_req : 3'b000);
      if (beep !== exp_beep(t, n, on, off)) eb++;
      if (grant !== g || busy !== 1'b1) eg++;
      if (done === 1'b1) begin
        dn++;
        dpos = t;
      end
      if (prev && beep === 1'b0) lows++;
      prev = beep;
    end
    chk($sformatf("%s beep waveform errors", nm), eb, 0);
    chk($sformatf("%s grant/busy errors", nm), eg, 0);
    chk($sformatf("%s done count", nm), dn, 1);
    chk($sformatf("%s done position", nm), dpos, len - 1);
    chk($sformatf("%s low intervals", nm), lows, n);
    step(1'b0, 3'b000);
    chk($sformatf("%s idle after", nm), {beep, busy, grant, done}, 6'b100000);
  endtask

  initial begin
    int nonidle;

    // Reset with all requests held, then a single ch0 pattern; cycle index = vector index.
    for (int i = 0; i < 26; i++) begin
      vecs[i].rst = (i < 3);
      vecs[i].req = (i < 3) ? 3'b111 : ((i == 10) ? 3'b001 : 3'b000);
      vecs[i].chk = (i > 0);
      vecs[i].exp = 6'b100000;
      if (i >= 12 && i <= 15) vecs[i].exp = 6'b010010;
      if (i >= 16 && i <= 22) vecs[i].exp = 6'b110010;
      if (i == 23)            vecs[i].exp = 6'b110011;
    end

    // Cycle 0 begins at the first posedge, which also samples the reset.
    rst = 1'b1;
    req = 3'b111;
    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      if (i > 0) step(vecs[i].rst, vecs[i].req);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), {beep, busy, grant, done}, vecs[i].exp);
    end

    // ch1 alone.
    step(1'b0, 3'b010);
    step(1'b0, 3'b000);
    chk("ch1 idle before grant", {beep, grant}, 4'b1000);
    play("ch1", 2, 2, 1, 3'b010, -1, 3'b000);

    // Simultaneous ch1+ch0: ch1 first, ch0 right after the idle cycle.
    step(1'b0, 3'b011);
    step(1'b0, 3'b000);
    play("prio ch1", 2, 2, 1, 3'b010, -1, 3'b000);
    play("prio ch0", 1, 1, 1, 3'b001, -1, 3'b000);

    // ch2 requested during ch0 does not preempt it.
    step(1'b0, 3'b001);
    step(1'b0, 3'b000);
    play("np ch0", 1, 1, 1, 3'b001, 3, 3'b100);
    play("np ch2", 3, 1, 2, 3'b100, -1, 3'b000);

    // Re-request during ch0's gap replays exactly once.
    step(1'b0, 3'b001);
    step(1'b0, 3'b000);
    play("rr ch0", 1, 1, 1, 3'b001, 6, 3'b001);
    play("rr ch0 replay", 1, 1, 1, 3'b001, -1, 3'b000);
    step(1'b0, 3'b000);
    chk("rr no second replay busy", busy, 1'b0);

    // Reset during ch2's second ON drops the pattern and any pending request.
    step(1'b0, 3'b100);
    step(1'b0, 3'b000);
    for (int t = 0; t < 14; t++) begin
      step(t == 13, (t == 5) ? 3'b001 : ((t == 13) ? 3'b100 : 3'b000));
      if (t == 12) chk("mr second on beep", beep, 1'b0);
      if (t == 13) chk("mr pre-reset grant", {beep, grant}, 4'b0100);
    end
    step(1'b0, 3'b000);
    chk("mr after reset", {beep, busy, grant, done}, 6'b100000);
    nonidle = 0;
    for (int t = 0; t < 20; t++) begin
      step(1'b0, 3'b000);
      if ({beep, busy, grant, done} !== 6'b100000) nonidle++;
    end
    chk("mr no replay", nonidle, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
